// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer, in-order retire, CDB capture, 2 lookup ports.
// Define ROB_FLUSH_EN to add the flush/flush_tag squash ports.
module rob_param #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = $clog2(DEPTH),
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [TAG_W-1:0]  lk_tag0,
    input  logic [TAG_W-1:0]  lk_tag1,
    output logic              lk_ready0,
    output logic              lk_ready1,
    output logic [DATA_W-1:0] lk_data0,
    output logic [DATA_W-1:0] lk_data1,
`ifdef ROB_FLUSH_EN
    input  logic              flush,
    input  logic [TAG_W-1:0]  flush_tag,
`endif
    output logic              commit_valid,
    output logic [REG_W-1:0]  commit_dest,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [TAG_W:0]    count,
    output logic              empty,
    output logic              full
);
    logic [DEPTH-1:0]  r_busy, r_rdy;
    logic [REG_W-1:0]  r_dest [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [TAG_W-1:0]  r_head, r_tail;
    logic [TAG_W:0]    r_count;
    logic              w_commit, w_alloc, w_flush;
    logic [DEPTH-1:0]  w_kill;
    logic [TAG_W-1:0]  w_ftail;
    logic [TAG_W:0]    w_fcnt;

    assign count       = r_count;
    assign full        = r_count == (TAG_W+1)'(DEPTH);
    assign empty       = r_count == '0;
    assign alloc_ready = !full;
    assign alloc_tag   = r_tail;
    assign w_commit    = r_busy[r_head] && r_rdy[r_head];
    assign w_alloc     = alloc_valid && alloc_ready && !w_flush;

`ifdef ROB_FLUSH_EN
    logic [TAG_W-1:0] w_off;
    assign w_off   = flush_tag - r_head;
    assign w_flush = flush && ({1'b0, w_off} < r_count);
    assign w_ftail = flush_tag + 1'b1;
    assign w_fcnt  = {1'b0, w_off} + 1'b1;
    // Entries strictly younger than flush_tag, measured as age from head, are squashed.
    for (genvar g = 0; g < DEPTH; g++) begin : g_kill
        logic [TAG_W-1:0] w_age;
        assign w_age     = TAG_W'(g) - r_head;
        assign w_kill[g] = w_flush && (w_age > w_off) && ({1'b0, w_age} < r_count);
    end
`else
    assign w_flush = 1'b0;
    assign w_ftail = '0;
    assign w_fcnt  = '0;
    assign w_kill  = '0;
`endif

    // Stored value wins; otherwise forward a same-cycle CDB broadcast.
    assign lk_ready0 = r_busy[lk_tag0] && (r_rdy[lk_tag0] || (wb_valid && wb_tag == lk_tag0));
    assign lk_ready1 = r_busy[lk_tag1] && (r_rdy[lk_tag1] || (wb_valid && wb_tag == lk_tag1));
    assign lk_data0  = !lk_ready0 ? '0 : r_rdy[lk_tag0] ? r_data[lk_tag0] : wb_data;
    assign lk_data1  = !lk_ready1 ? '0 : r_rdy[lk_tag1] ? r_data[lk_tag1] : wb_data;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_busy       <= '0;
            r_rdy        <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            commit_valid <= 1'b0;
            commit_dest  <= '0;
            commit_data  <= '0;
            commit_tag   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_valid && wb_tag == TAG_W'(i) && r_busy[i] && !w_kill[i]) begin
                    r_data[i] <= wb_data;
                    r_rdy[i]  <= 1'b1;
                end
                if (w_kill[i] || (w_commit && r_head == TAG_W'(i)))
                    r_busy[i] <= 1'b0;
            end
            if (w_alloc) begin
                r_busy[r_tail] <= 1'b1;
                r_rdy[r_tail]  <= 1'b0;
                r_dest[r_tail] <= alloc_dest;
            end
            commit_valid <= w_commit;
            if (w_commit) begin
                commit_dest <= r_dest[r_head];
                commit_data <= r_data[r_head];
                commit_tag  <= r_head;
                r_head      <= r_head + 1'b1;
            end
            r_tail  <= w_flush ? w_ftail : r_tail + TAG_W'(w_alloc);
            r_count <= (w_flush ? w_fcnt : r_count + (TAG_W+1)'(w_alloc)) - (TAG_W+1)'(w_commit);
        end
    end
endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed stimulus, queue-based reference model checked every cycle.
module tb_rob_param;
    logic        clk1 = 0, rst = 1;
    logic        alloc_valid = 0, alloc_ready;
    logic [3:0]  alloc_dest = 0;
    logic [2:0]  alloc_tag;
    logic        wb_valid = 0;
    logic [2:0]  wb_tag = 0;
    logic [15:0] wb_data = 0;
    logic [2:0]  lk_tag0 = 0, lk_tag1 = 0;
    logic        lk_ready0, lk_ready1;
    logic [15:0] lk_data0, lk_data1;
    logic        flush = 0;
    logic [2:0]  flush_tag = 0;
    logic        commit_valid;
    logic [3:0]  commit_dest;
    logic [15:0] commit_data;
    logic [2:0]  commit_tag;
    logic [3:0]  count;
    logic        empty, full;
    int checks = 0, errors = 0;

    always #5 clk1 = ~clk1;

    rob_param dut (
        .clk1(clk1), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .lk_tag0(lk_tag0), .lk_tag1(lk_tag1),
        .lk_ready0(lk_ready0), .lk_ready1(lk_ready1),
        .lk_data0(lk_data0), .lk_data1(lk_data1),
`ifdef ROB_FLUSH_EN
        .flush(flush), .flush_tag(flush_tag),
`endif
        .commit_valid(commit_valid), .commit_dest(commit_dest),
        .commit_data(commit_data), .commit_tag(commit_tag),
        .count(count), .empty(empty), .full(full)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: the queue holds live entries oldest first.
    typedef struct {
        logic [2:0]  tag;
        logic [3:0]  dest;
        bit          rdy;
        logic [15:0] data;
    } ent_t;
    ent_t q[$];
    logic [2:0]  m_tail = 0;
    bit          m_live = 0, m_cv = 0;
    logic [3:0]  m_cd = 0;
    logic [15:0] m_cdata = 0;
    logic [2:0]  m_ct = 0;

    always @(posedge clk1) begin
        int n, fk;
        bit com, fl;
        ent_t e;
        if (rst) begin
            q.delete();
            m_tail = 0;
            m_cv = 0;
            m_live = 1;
        end else if (m_live) begin
            n = q.size();
            com = n > 0 && q[0].rdy;
            fl = 0;
            fk = -1;
`ifdef ROB_FLUSH_EN
            if (flush) foreach (q[k]) if (q[k].tag == flush_tag) fk = k;
`endif
            if (fk >= 0) begin
                while (q.size() > fk + 1) void'(q.pop_back());
                m_tail = flush_tag + 3'd1;
                fl = 1;
            end
            if (wb_valid) foreach (q[k]) if (q[k].tag == wb_tag) begin
                q[k].rdy = 1;
                q[k].data = wb_data;
            end
            m_cv = com;
            if (com) begin
                e = q.pop_front();
                m_cd = e.dest;
                m_cdata = e.data;
                m_ct = e.tag;
            end
            if (alloc_valid && !fl && n < 8) begin
                q.push_back('{m_tail, alloc_dest, 1'b0, 16'h0});
                m_tail = m_tail + 3'd1;
            end
        end
    end

    function automatic logic [16:0] m_lk(input logic [2:0] t);
        foreach (q[k]) if (q[k].tag == t) begin
            if (q[k].rdy) return {1'b1, q[k].data};
            if (wb_valid && wb_tag == t) return {1'b1, wb_data};
        end
        return 17'h0;
    endfunction

    always @(negedge clk1) begin
        if (m_live) begin
            chk("count", count, q.size());
            chk("empty", empty, q.size() == 0);
            chk("full", full, q.size() == 8);
            chk("alloc_ready", alloc_ready, q.size() != 8);
            chk("alloc_tag", alloc_tag, m_tail);
            chk("commit_valid", commit_valid, m_cv);
            if (m_cv) begin
                chk("commit_dest", commit_dest, m_cd);
                chk("commit_data", commit_data, m_cdata);
                chk("commit_tag", commit_tag, m_ct);
            end
            chk("lk0", {lk_ready0, lk_data0}, m_lk(lk_tag0));
            chk("lk1", {lk_ready1, lk_data1}, m_lk(lk_tag1));
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic alloc_n(input int n);
        alloc_valid = 1;
        for (int i = 0; i < n; i++) begin
            alloc_dest = 4'(i + 1);
            tick();
        end
        alloc_valid = 0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_commit_valid", commit_valid, 0);
        rst = 0;
        // 1: alloc R1..R3, out-of-order writeback, in-order commit
        alloc_n(3);
        chk("t1_count", count, 3);
        chk("t1_tail", alloc_tag, 3);
        wb_valid = 1; wb_tag = 1; wb_data = 16'h22; tick();
        chk("t1_no_commit_yet", commit_valid, 0);
        wb_tag = 0; wb_data = 16'h11; tick();
        wb_valid = 0; tick();
        chk("t1_c1_valid", commit_valid, 1);
        chk("t1_c1_dest", commit_dest, 1);
        chk("t1_c1_data", commit_data, 16'h11);
        tick();
        chk("t1_c2_valid", commit_valid, 1);
        chk("t1_c2_dest", commit_dest, 2);
        chk("t1_c2_data", commit_data, 16'h22);
        tick();
        chk("t1_pending", commit_valid, 0);
        chk("t1_count1", count, 1);
        // 2: fill to full, overflow ignored, wrap
        do_reset();
        alloc_n(8);
        chk("t2_full", full, 1);
        chk("t2_ready", alloc_ready, 0);
        chk("t2_tail", alloc_tag, 0);
        alloc_valid = 1; alloc_dest = 4'd9; tick(); alloc_valid = 0;
        chk("t2_overflow_count", count, 8);
        wb_valid = 1; wb_tag = 0; wb_data = 16'hA0; tick(); wb_valid = 0;
        tick();
        chk("t2_commit_tag", commit_tag, 0);
        chk("t2_count7", count, 7);
        chk("t2_wrap_tag", alloc_tag, 0);
        alloc_valid = 1; alloc_dest = 4'd9; tick(); alloc_valid = 0;
        chk("t2_refull", count, 8);
        // 3: full with ready head plus alloc: commit wins, alloc next cycle
        wb_valid = 1; wb_tag = 1; wb_data = 16'hB1; tick(); wb_valid = 0;
        alloc_valid = 1; alloc_dest = 4'd10; tick();
        chk("t3_commit", commit_valid, 1);
        chk("t3_commit_tag", commit_tag, 1);
        chk("t3_refused", count, 7);
        chk("t3_tail", alloc_tag, 1);
        tick(); alloc_valid = 0;
        chk("t3_accept", count, 8);
        chk("t3_tail2", alloc_tag, 2);
        // 4: CDB forwarding on lookup
        lk_tag0 = 3; lk_tag1 = 4;
        wb_valid = 1; wb_tag = 3; wb_data = 16'h5A; #1;
        chk("t4_fwd_ready", lk_ready0, 1);
        chk("t4_fwd_data", lk_data0, 16'h5A);
        chk("t4_other", lk_ready1, 0);
        tick(); wb_valid = 0; #1;
        chk("t4_stored", {lk_ready0, lk_data0}, {1'b1, 16'h5A});
        // 6: reset mid-operation
        do_reset();
        alloc_n(5);
        rst = 1; tick();
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_cv", commit_valid, 0);
        chk("t6_tag", alloc_tag, 0);
        rst = 0;
        chk("t6_lk_unalloc", {lk_ready0, lk_data0}, 17'h0);
`ifdef ROB_FLUSH_EN
        // 5: flush beats alloc, squashed writeback dropped, out-of-window flush ignored
        alloc_n(6);
        flush = 1; flush_tag = 2; alloc_valid = 1; tick();
        flush = 0; alloc_valid = 0;
        chk("t5_tail", alloc_tag, 3);
        chk("t5_count", count, 3);
        wb_valid = 1; wb_tag = 4; wb_data = 16'h44; tick(); wb_valid = 0;
        lk_tag0 = 4; tick();
        chk("t5_wb_dropped", lk_ready0, 0);
        chk("t5_no_commit", commit_valid, 0);
        flush = 1; flush_tag = 5; tick(); flush = 0;
        chk("t5_bad_flush", count, 3);
        do_reset();
`endif
        // mixed traffic against the model
        for (int i = 0; i < 120; i++) begin
            alloc_valid = (i % 3) != 0;
            alloc_dest = 4'(i * 7);
            wb_valid = (i % 2) == 0;
            wb_tag = 3'(i * 5);
            wb_data = 16'(i * 16'h0101 + 3);
            lk_tag0 = 3'(i);
            lk_tag1 = 3'(i * 3 + 1);
`ifdef ROB_FLUSH_EN
            flush = (i % 17) == 16;
            flush_tag = 3'(i + 2);
`endif
            tick();
        end
        alloc_valid = 0; wb_valid = 0; flush = 0;
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
